// File: rtl/envase_pkg.sv
// Shared state codes and default timing/capacity values for the sealing station.
package envase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADVANCE = 3'd1,
    ST_SEAL    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_STALL   = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  localparam int SEAL_CYCLES_DEF = 4;
  localparam int CAP_MAX_DEF     = 15;
  localparam int CAP_W_DEF       = 4;
  localparam int JAM_CYCLES_DEF  = 32;

endpackage

// File: rtl/sealing_station_ctrl_sync2.sv
// Two-flop synchronizer for an asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sealing_station_ctrl.sv
// Capping/sealing station sequencer: conveyor advance, timed seal, release with
// jam detection, and cap magazine tracking.
//   state   | meaning
//   IDLE    | line stopped, waiting for enable
//   ADVANCE | conveyor running, waiting for a bottle
//   SEAL    | actuator on for SEAL_CYCLES
//   RELEASE | conveyor running until the bottle clears
//   STALL   | bottle present but magazine empty
//   FAULT   | bottle did not clear, waits for operator
module sealing_station_ctrl
  import envase_pkg::*;
#(
  parameter int SEAL_CYCLES = SEAL_CYCLES_DEF,
  parameter int CAP_MAX     = CAP_MAX_DEF,
  parameter int CAP_W       = CAP_W_DEF,
  parameter int JAM_CYCLES  = JAM_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic             bottle_sensor,
  input  logic             cap_refill,
  input  logic             fault_clr,
  output logic             conveyor_run,
  output logic             seal_act,
  output logic             sealed_pulse,
  output logic [CAP_W-1:0] cap_count,
  output logic             cap_empty,
  output logic             jam_fault,
  output logic [2:0]       state_o
);

  localparam int TMAX = (SEAL_CYCLES > JAM_CYCLES) ? SEAL_CYCLES : JAM_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  logic             sens;
  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CAP_W-1:0] cap_q, cap_d;
  logic             conveyor_run_q, conveyor_run_d;
  logic             seal_act_q, seal_act_d;
  logic             sealed_pulse_q, sealed_pulse_d;
  logic             cap_empty_q, cap_empty_d;
  logic             jam_fault_q, jam_fault_d;
  logic             seal_done;

  sync2 u_sync_sensor (
    .clk (CLK),
    .rst (RST),
    .d   (bottle_sensor),
    .q   (sens)
  );

  assign seal_done = (state_q == ST_SEAL) && (timer_q == TW'(SEAL_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      cap_q          <= CAP_W'(CAP_MAX);
      conveyor_run_q <= 1'b0;
      seal_act_q     <= 1'b0;
      sealed_pulse_q <= 1'b0;
      cap_empty_q    <= 1'b0;
      jam_fault_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      cap_q          <= cap_d;
      conveyor_run_q <= conveyor_run_d;
      seal_act_q     <= seal_act_d;
      sealed_pulse_q <= sealed_pulse_d;
      cap_empty_q    <= cap_empty_d;
      jam_fault_q    <= jam_fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (enable) state_d = ST_ADVANCE;
      ST_ADVANCE: begin
        if (!enable)                 state_d = ST_IDLE;
        else if (sens && cap_q != 0) state_d = ST_SEAL;
        else if (sens)               state_d = ST_STALL;
      end
      ST_SEAL:    if (seal_done) state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!sens)                                  state_d = enable ? ST_ADVANCE : ST_IDLE;
        else if (timer_q == TW'(JAM_CYCLES - 1))    state_d = ST_FAULT;
      end
      ST_STALL:   if (cap_q != 0) state_d = ST_SEAL;
      ST_FAULT:   if (fault_clr) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    timer_d = '0;
    if (state_d == state_q && (state_q == ST_SEAL || state_q == ST_RELEASE))
      timer_d = timer_q + TW'(1);

    cap_d = cap_q;
    if (cap_refill)
      cap_d = CAP_W'(CAP_MAX);
    else if (seal_done && cap_q != 0)
      cap_d = cap_q - CAP_W'(1);

    conveyor_run_d = (state_d == ST_ADVANCE) || (state_d == ST_RELEASE);
    seal_act_d     = (state_d == ST_SEAL);
    cap_empty_d    = (state_d == ST_STALL);
    jam_fault_d    = (state_d == ST_FAULT);
    sealed_pulse_d = seal_done;
  end

  assign conveyor_run = conveyor_run_q;
  assign seal_act     = seal_act_q;
  assign sealed_pulse = sealed_pulse_q;
  assign cap_count    = cap_q;
  assign cap_empty    = cap_empty_q;
  assign jam_fault    = jam_fault_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_sealing_station_ctrl.sv
// Scenario bench for the sealing station; a bottle-level model tracks caps and pulses.
module tb_sealing_station_ctrl;

  localparam int SEALC = 4;
  localparam int CAPM  = 15;
  localparam int JAMC  = 32;
  localparam int S_IDLE = 0, S_ADV = 1, S_SEAL = 2, S_REL = 3, S_STALL = 4, S_FAULT = 5;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       enable = 1'b0;
  logic       bottle_sensor = 1'b0;
  logic       cap_refill = 1'b0;
  logic       fault_clr = 1'b0;
  logic       conveyor_run, seal_act, sealed_pulse, cap_empty, jam_fault;
  logic [3:0] cap_count;
  logic [2:0] state_o;

  int n_pass = 0;
  int n_total = 0;
  int cap_model = CAPM;

  always #5 CLK = ~CLK;

  sealing_station_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .enable        (enable),
    .bottle_sensor (bottle_sensor),
    .cap_refill    (cap_refill),
    .fault_clr     (fault_clr),
    .conveyor_run  (conveyor_run),
    .seal_act      (seal_act),
    .sealed_pulse  (sealed_pulse),
    .cap_count     (cap_count),
    .cap_empty     (cap_empty),
    .jam_fault     (jam_fault),
    .state_o       (state_o)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Feeds one bottle from ADVANCE and reports what the station did with it.
  task automatic run_bottle(input int hold, output int seal_n, output int pulse_n,
                            output int cap_at_pulse, output int back);
    seal_n = 0; pulse_n = 0; cap_at_pulse = -1; back = 0;
    bottle_sensor = 1'b1;
    for (int i = 0; i < 20 && pulse_n == 0; i++) begin
      tick();
      if (seal_act) seal_n++;
      if (sealed_pulse) begin
        pulse_n++;
        cap_at_pulse = int'(cap_count);
      end
    end
    repeat (hold) begin
      tick();
      if (seal_act) seal_n++;
      if (sealed_pulse) pulse_n++;
    end
    bottle_sensor = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sealed_pulse) pulse_n++;
      if (state_o == 3'(S_ADV)) begin
        back = 1;
        break;
      end
    end
  endtask

  task automatic bottle_checked(input string tag);
    int s, p, c, b;
    run_bottle($urandom_range(0, 6), s, p, c, b);
    cap_model = cap_model - 1;
    n_total++; if (s !== SEALC) $display("FAIL %s seal_cycles: got %0d expected %0d", tag, s, SEALC); else n_pass++;
    n_total++; if (p !== 1) $display("FAIL %s pulses: got %0d expected 1", tag, p); else n_pass++;
    n_total++; if (c !== cap_model) $display("FAIL %s cap_at_pulse: got %0d expected %0d", tag, c, cap_model); else n_pass++;
    n_total++; if (b !== 1) $display("FAIL %s back_to_advance: got %0d expected 1", tag, b); else n_pass++;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    n_total++; if (state_o !== 3'd0) $display("FAIL rst_state: got %0d expected 0", state_o); else n_pass++;
    n_total++; if ({conveyor_run, seal_act, sealed_pulse, cap_empty, jam_fault} !== 5'b0)
      $display("FAIL rst_outputs: got %b expected 00000", {conveyor_run, seal_act, sealed_pulse, cap_empty, jam_fault}); else n_pass++;
    n_total++; if (cap_count !== 4'(CAPM)) $display("FAIL rst_cap: got %0d expected %0d", cap_count, CAPM); else n_pass++;
    RST = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    n_total++; if (state_o !== 3'(S_ADV)) $display("FAIL en_state: got %0d expected %0d", state_o, S_ADV); else n_pass++;
    n_total++; if (conveyor_run !== 1'b1) $display("FAIL en_conveyor: got %b expected 1", conveyor_run); else n_pass++;
    n_total++; if ({seal_act, sealed_pulse, cap_empty, jam_fault} !== 4'b0 || cap_count !== 4'(CAPM))
      $display("FAIL en_others: got %b cap %0d expected 0000 cap %0d", {seal_act, sealed_pulse, cap_empty, jam_fault}, cap_count, CAPM); else n_pass++;
  endtask

  task automatic test_single_seal();
    int n;
    bottle_sensor = 1'b1;
    tick(); tick();
    n_total++; if (state_o !== 3'(S_ADV)) $display("FAIL sync_lag: got %0d expected %0d", state_o, S_ADV); else n_pass++;
    tick();
    n_total++; if (state_o !== 3'(S_SEAL) || seal_act !== 1'b1) $display("FAIL seal_entry: got state %0d act %b expected %0d 1", state_o, seal_act, S_SEAL); else n_pass++;
    n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (seal_act) n++; else break;
    end
    n_total++; if (n !== SEALC) $display("FAIL seal_len: got %0d expected %0d", n, SEALC); else n_pass++;
    cap_model = CAPM - 1;
    n_total++; if (sealed_pulse !== 1'b1 || cap_count !== 4'(cap_model) || conveyor_run !== 1'b1 || state_o !== 3'(S_REL))
      $display("FAIL seal_release: got pulse %b cap %0d conv %b state %0d expected 1 %0d 1 %0d", sealed_pulse, cap_count, conveyor_run, state_o, cap_model, S_REL); else n_pass++;
    tick();
    n_total++; if (sealed_pulse !== 1'b0) $display("FAIL pulse_width: got %b expected 0", sealed_pulse); else n_pass++;
    bottle_sensor = 1'b0;
    for (int i = 0; i < 6 && state_o != 3'(S_ADV); i++) tick();
    n_total++; if (state_o !== 3'(S_ADV)) $display("FAIL release_back: got %0d expected %0d", state_o, S_ADV); else n_pass++;
  endtask

  task automatic test_magazine();
    while (cap_model > 0) bottle_checked("mag_bottle");
    n_total++; if (cap_count !== 4'd0) $display("FAIL mag_zero: got %0d expected 0", cap_count); else n_pass++;
    bottle_sensor = 1'b1;
    for (int i = 0; i < 6 && state_o != 3'(S_STALL); i++) tick();
    n_total++; if (state_o !== 3'(S_STALL) || cap_empty !== 1'b1 || conveyor_run !== 1'b0 || seal_act !== 1'b0)
      $display("FAIL stall_enter: got state %0d empty %b conv %b act %b expected %0d 1 0 0", state_o, cap_empty, conveyor_run, seal_act, S_STALL); else n_pass++;
    repeat ($urandom_range(2, 5)) tick();
    n_total++; if (state_o !== 3'(S_STALL)) $display("FAIL stall_hold: got %0d expected %0d", state_o, S_STALL); else n_pass++;
    cap_refill = 1'b1;
    tick();
    cap_refill = 1'b0;
    n_total++; if (cap_count !== 4'(CAPM)) $display("FAIL stall_refill: got %0d expected %0d", cap_count, CAPM); else n_pass++;
    tick();
    n_total++; if (state_o !== 3'(S_SEAL)) $display("FAIL stall_to_seal: got %0d expected %0d", state_o, S_SEAL); else n_pass++;
    for (int i = 0; i < 10 && !sealed_pulse; i++) tick();
    cap_model = CAPM - 1;
    n_total++; if (sealed_pulse !== 1'b1 || cap_count !== 4'(cap_model))
      $display("FAIL stall_pulse: got pulse %b cap %0d expected 1 %0d", sealed_pulse, cap_count, cap_model); else n_pass++;
    bottle_sensor = 1'b0;
    for (int i = 0; i < 8 && state_o != 3'(S_ADV); i++) tick();
  endtask

  task automatic test_jam();
    int rel;
    bottle_sensor = 1'b1;
    for (int i = 0; i < 20 && state_o != 3'(S_REL); i++) tick();
    rel = 0;
    for (int i = 0; i < 60 && state_o == 3'(S_REL); i++) begin
      rel++;
      tick();
    end
    cap_model = cap_model - 1;
    n_total++; if (rel !== JAMC) $display("FAIL jam_release_len: got %0d expected %0d", rel, JAMC); else n_pass++;
    n_total++; if (state_o !== 3'(S_FAULT) || jam_fault !== 1'b1 || conveyor_run !== 1'b0 || seal_act !== 1'b0)
      $display("FAIL jam_fault: got state %0d jam %b conv %b act %b expected %0d 1 0 0", state_o, jam_fault, conveyor_run, seal_act, S_FAULT); else n_pass++;
    n_total++; if (cap_count !== 4'(cap_model)) $display("FAIL jam_cap: got %0d expected %0d", cap_count, cap_model); else n_pass++;
    bottle_sensor = 1'b0;
    repeat ($urandom_range(1, 5)) tick();
    n_total++; if (state_o !== 3'(S_FAULT)) $display("FAIL jam_hold: got %0d expected %0d", state_o, S_FAULT); else n_pass++;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    n_total++; if (state_o !== 3'(S_IDLE) || jam_fault !== 1'b0) $display("FAIL jam_clear: got state %0d jam %b expected 0 0", state_o, jam_fault); else n_pass++;
    tick();
    n_total++; if (state_o !== 3'(S_ADV)) $display("FAIL jam_restart: got %0d expected %0d", state_o, S_ADV); else n_pass++;
  endtask

  task automatic test_refill_collision();
    int n;
    while (cap_model > 5) bottle_checked("pre_collide");
    bottle_sensor = 1'b1;
    for (int i = 0; i < 10 && !seal_act; i++) tick();
    n = seal_act ? 1 : 0;
    for (int i = 0; i < 10 && n < SEALC; i++) begin
      tick();
      if (seal_act) n++;
    end
    cap_refill = 1'b1;
    tick();
    cap_refill = 1'b0;
    cap_model = CAPM;
    n_total++; if (sealed_pulse !== 1'b1 || cap_count !== 4'(cap_model))
      $display("FAIL refill_collide: got pulse %b cap %0d expected 1 %0d", sealed_pulse, cap_count, cap_model); else n_pass++;
    bottle_sensor = 1'b0;
    for (int i = 0; i < 8 && state_o != 3'(S_ADV); i++) tick();
  endtask

  task automatic test_reset_mid_seal();
    int p;
    bottle_sensor = 1'b1;
    for (int i = 0; i < 10 && state_o != 3'(S_SEAL); i++) tick();
    tick();
    RST = 1'b1;
    bottle_sensor = 1'b0;
    #1;
    n_total++; if ({conveyor_run, seal_act, sealed_pulse, cap_empty, jam_fault} !== 5'b0 || state_o !== 3'd0 || cap_count !== 4'(CAPM))
      $display("FAIL rst_mid_seal: got outs %b state %0d cap %0d expected 00000 0 %0d",
               {conveyor_run, seal_act, sealed_pulse, cap_empty, jam_fault}, state_o, cap_count, CAPM); else n_pass++;
    tick();
    RST = 1'b0;
    cap_model = CAPM;
    p = 0;
    repeat (12) begin
      tick();
      if (sealed_pulse) p++;
    end
    n_total++; if (p !== 0) $display("FAIL rst_no_pulse: got %0d expected 0", p); else n_pass++;
    n_total++; if (state_o !== 3'(S_ADV)) $display("FAIL rst_resume: got %0d expected %0d", state_o, S_ADV); else n_pass++;
  endtask

  task automatic test_enable_drop();
    int s, p, c;
    bottle_sensor = 1'b1;
    for (int i = 0; i < 10 && state_o != 3'(S_SEAL); i++) tick();
    s = seal_act ? 1 : 0; p = 0; c = -1;
    enable = 1'b0;
    repeat (10) begin
      tick();
      if (seal_act) s++;
      if (sealed_pulse) begin
        p++;
        c = int'(cap_count);
      end
    end
    cap_model = cap_model - 1;
    n_total++; if (s !== SEALC || p !== 1 || c !== cap_model)
      $display("FAIL en_drop_seal: got seal %0d pulses %0d cap %0d expected %0d 1 %0d", s, p, c, SEALC, cap_model); else n_pass++;
    bottle_sensor = 1'b0;
    for (int i = 0; i < 8 && state_o != 3'(S_IDLE); i++) tick();
    n_total++; if (state_o !== 3'(S_IDLE) || conveyor_run !== 1'b0)
      $display("FAIL en_drop_idle: got state %0d conv %b expected 0 0", state_o, conveyor_run); else n_pass++;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 16; it++) begin
      r = $urandom_range(0, 3);
      if (r == 0 || cap_model == 0) begin
        cap_refill = 1'b1;
        tick();
        cap_refill = 1'b0;
        cap_model = CAPM;
        n_total++; if (cap_count !== 4'(cap_model)) $display("FAIL rnd_refill: got %0d expected %0d", cap_count, cap_model); else n_pass++;
      end else if (r == 1) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
        n_total++; if (state_o !== 3'(S_IDLE) || conveyor_run !== 1'b0) $display("FAIL rnd_idle: got state %0d conv %b expected 0 0", state_o, conveyor_run); else n_pass++;
        enable = 1'b1;
        tick();
        n_total++; if (state_o !== 3'(S_ADV)) $display("FAIL rnd_resume: got %0d expected %0d", state_o, S_ADV); else n_pass++;
      end else begin
        bottle_checked("rnd_bottle");
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_seal();
    test_magazine();
    test_jam();
    test_refill_collision();
    test_reset_mid_seal();
    test_enable_drop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
